// File: rtl/jk_ff_bank.sv
// Bank of WIDTH independent JK flip-flops with enable, parallel load and an optional slave stage.
// Each channel also has a change pulse and a saturating transition counter.
module jk_ff_bank #(
  parameter int WIDTH = 8,
  parameter int MS_MODE = 1,
  parameter int CNT_W = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_data,
  input  logic [WIDTH-1:0]       j,
  input  logic [WIDTH-1:0]       k,
  input  logic                   cnt_clr,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       q_bar,
  output logic [WIDTH-1:0]       changed,
  output logic [WIDTH*CNT_W-1:0] toggle_cnt
);

  logic [WIDTH-1:0] master_r;
  logic [WIDTH-1:0] m_next_s;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] q_next_s;
  logic [WIDTH-1:0] changed_r;

  // Master next state: load beats enable, and JK feedback always comes from the master.
  always_comb begin
    m_next_s = master_r;
    for (int i = 0; i < WIDTH; i++) begin
      if (load) begin
        m_next_s[i] = load_data[i];
      end else if (!en) begin
        m_next_s[i] = master_r[i];
      end else begin
        case ({j[i], k[i]})
          2'b00:   m_next_s[i] = master_r[i];
          2'b01:   m_next_s[i] = 1'b0;
          2'b10:   m_next_s[i] = 1'b1;
          2'b11:   m_next_s[i] = ~master_r[i];
          default: m_next_s[i] = master_r[i];
        endcase
      end
    end
  end

  // Master register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      master_r <= RESET_VAL;
    end else begin
      master_r <= m_next_s;
    end
  end

  generate
    if (MS_MODE != 0) begin : g_ms
      logic [WIDTH-1:0] slave_r;

      // Slave copies the master every edge so the pipeline always drains.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slave_r <= RESET_VAL;
        end else begin
          slave_r <= master_r;
        end
      end

      assign q_s      = slave_r;
      assign q_next_s = master_r;
    end else begin : g_ss
      assign q_s      = master_r;
      assign q_next_s = m_next_s;
    end
  endgenerate

  // Change pulse, aligned with the edge on which q moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed_r <= {WIDTH{1'b0}};
    end else begin
      changed_r <= q_next_s ^ q_s;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_r;

      // Saturating transition counter; clear wins over a simultaneous increment.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
          cnt_r <= {CNT_W{1'b0}};
        end else if ((q_next_s[gi] != q_s[gi]) && (cnt_r != {CNT_W{1'b1}})) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end else begin
          cnt_r <= cnt_r;
        end
      end

      assign toggle_cnt[gi*CNT_W +: CNT_W] = cnt_r;
    end
  endgenerate

  assign q       = q_s;
  assign q_bar   = ~q_s;
  assign changed = changed_r;

endmodule

// File: tb/tb_jk_ff_bank.sv
// Directed bench: master-slave, single-stage and narrow-counter instances share one stimulus set.
module tb_jk_ff_bank;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [3:0] load_data;
  logic [3:0] j;
  logic [3:0] k;
  logic       cnt_clr;

  logic [3:0]  ms_q, ms_qb, ms_chg;
  logic [31:0] ms_cnt;
  logic [3:0]  ss_q, ss_qb, ss_chg;
  logic [31:0] ss_cnt;
  logic [3:0]  st_q, st_qb, st_chg;
  logic [7:0]  st_cnt;

  int n_vec;
  int n_err;

  jk_ff_bank #(.WIDTH(4), .MS_MODE(1), .CNT_W(8)) u_ms (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_data(load_data),
    .j(j), .k(k), .cnt_clr(cnt_clr),
    .q(ms_q), .q_bar(ms_qb), .changed(ms_chg), .toggle_cnt(ms_cnt)
  );

  jk_ff_bank #(.WIDTH(4), .MS_MODE(0), .CNT_W(8)) u_ss (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_data(load_data),
    .j(j), .k(k), .cnt_clr(cnt_clr),
    .q(ss_q), .q_bar(ss_qb), .changed(ss_chg), .toggle_cnt(ss_cnt)
  );

  jk_ff_bank #(.WIDTH(4), .MS_MODE(0), .CNT_W(2)) u_st (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_data(load_data),
    .j(j), .k(k), .cnt_clr(cnt_clr),
    .q(st_q), .q_bar(st_qb), .changed(st_chg), .toggle_cnt(st_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    en = 1'b0; load = 1'b0; load_data = 4'b0000;
    j = 4'b0000; k = 4'b0000; cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({ms_q, ms_qb, ms_chg} !== {4'b0000, 4'b1111, 4'b0000}) begin
      n_err++; $display("FAIL reset_q: got q/qb/chg %b/%b/%b, want 0000/1111/0000", ms_q, ms_qb, ms_chg);
    end
    n_vec++;
    if ({ms_cnt, ss_cnt, st_cnt} !== 72'd0) begin
      n_err++; $display("FAIL reset_cnt: got %h %h %h, want zero", ms_cnt, ss_cnt, st_cnt);
    end
  endtask

  task automatic test_jk_truth();
    do_reset();
    en = 1'b1; j = 4'b0101; k = 4'b0011;
    tick();
    j = 4'b0000; k = 4'b0000;
    n_vec++;
    if ({ss_q, ss_chg, ss_cnt} !== {4'b0101, 4'b0101, 32'h00010001}) begin
      n_err++; $display("FAIL jk_ss_e1: got q %b chg %b cnt %h, want 0101 0101 00010001", ss_q, ss_chg, ss_cnt);
    end
    n_vec++;
    if ({ms_q, ms_chg, ms_cnt} !== {4'b0000, 4'b0000, 32'h0}) begin
      n_err++; $display("FAIL jk_ms_e1: got q %b chg %b cnt %h, want 0000 0000 0", ms_q, ms_chg, ms_cnt);
    end
    tick();
    n_vec++;
    if ({ms_q, ms_qb, ms_chg, ms_cnt} !== {4'b0101, 4'b1010, 4'b0101, 32'h00010001}) begin
      n_err++; $display("FAIL jk_ms_e2: got q %b qb %b chg %b cnt %h, want 0101 1010 0101 00010001", ms_q, ms_qb, ms_chg, ms_cnt);
    end
    n_vec++;
    if ({ss_q, ss_chg, st_cnt} !== {4'b0101, 4'b0000, 8'h11}) begin
      n_err++; $display("FAIL jk_ss_e2: got q %b chg %b cnt2 %h, want 0101 0000 11", ss_q, ss_chg, st_cnt);
    end
    tick();
    n_vec++;
    if ({ms_q, ms_chg, ms_cnt} !== {4'b0101, 4'b0000, 32'h00010001}) begin
      n_err++; $display("FAIL jk_ms_e3: got q %b chg %b cnt %h, want 0101 0000 00010001", ms_q, ms_chg, ms_cnt);
    end
  endtask

  task automatic test_toggle();
    logic [3:0] exp_ss [3];
    logic [3:0] exp_ms [3];
    exp_ss[0] = 4'b1111; exp_ss[1] = 4'b0000; exp_ss[2] = 4'b1111;
    exp_ms[0] = 4'b0000; exp_ms[1] = 4'b1111; exp_ms[2] = 4'b0000;
    do_reset();
    en = 1'b1; j = 4'b1111; k = 4'b1111;
    for (int e = 0; e < 3; e++) begin
      tick();
      n_vec++;
      if ({ss_q, ss_chg, ms_q} !== {exp_ss[e], 4'b1111, exp_ms[e]}) begin
        n_err++; $display("FAIL toggle_e%0d: got ss_q %b ss_chg %b ms_q %b, want %b 1111 %b", e + 1, ss_q, ss_chg, ms_q, exp_ss[e], exp_ms[e]);
      end
    end
    n_vec++;
    if ({ss_cnt, ms_cnt, st_cnt} !== {32'h03030303, 32'h02020202, 8'hFF}) begin
      n_err++; $display("FAIL toggle_cnt: got %h %h %h, want 03030303 02020202 ff", ss_cnt, ms_cnt, st_cnt);
    end
  endtask

  task automatic test_load_enable();
    do_reset();
    en = 1'b0; load = 1'b1; load_data = 4'b1100; j = 4'b1111; k = 4'b1111;
    tick();
    n_vec++;
    if ({ss_q, ss_chg, ms_q} !== {4'b1100, 4'b1100, 4'b0000}) begin
      n_err++; $display("FAIL load_e1: got ss_q %b ss_chg %b ms_q %b, want 1100 1100 0000", ss_q, ss_chg, ms_q);
    end
    load = 1'b0;
    tick();
    n_vec++;
    if ({ms_q, ms_chg, ss_q, ss_chg} !== {4'b1100, 4'b1100, 4'b1100, 4'b0000}) begin
      n_err++; $display("FAIL load_e2: got ms %b/%b ss %b/%b, want 1100/1100 1100/0000", ms_q, ms_chg, ss_q, ss_chg);
    end
    for (int e = 0; e < 3; e++) begin
      tick();
      n_vec++;
      if ({ms_q, ms_chg, ss_q, ss_chg, ms_cnt, ss_cnt} !== {4'b1100, 4'b0000, 4'b1100, 4'b0000, 32'h01010000, 32'h01010000}) begin
        n_err++; $display("FAIL hold_e%0d: got ms %b/%b ss %b/%b cnt %h %h, want 1100/0000 1100/0000 01010000", e + 3, ms_q, ms_chg, ss_q, ss_chg, ms_cnt, ss_cnt);
      end
    end
  endtask

  task automatic test_saturation_clear();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    do_reset();
    en = 1'b1; j = 4'b0001; k = 4'b0001;
    for (int e = 0; e < 5; e++) begin
      tick();
      n_vec++;
      if ({st_q[0], st_chg[0], st_cnt[1:0]} !== {~e[0], 1'b1, exp_cnt[e]}) begin
        n_err++; $display("FAIL sat_e%0d: got q0 %b chg0 %b cnt %0d, want %b 1 %0d", e + 1, st_q[0], st_chg[0], st_cnt[1:0], ~e[0], exp_cnt[e]);
      end
    end
    cnt_clr = 1'b1;
    tick();
    n_vec++;
    if ({st_q, st_chg, st_cnt} !== {4'b0000, 4'b0001, 8'h00}) begin
      n_err++; $display("FAIL clr_win: got q %b chg %b cnt %h, want 0000 0001 00", st_q, st_chg, st_cnt);
    end
    cnt_clr = 1'b0;
    tick();
    n_vec++;
    if ({st_q, st_cnt} !== {4'b0001, 8'h01}) begin
      n_err++; $display("FAIL clr_resume: got q %b cnt %h, want 0001 01", st_q, st_cnt);
    end
  endtask

  task automatic test_equal_load();
    do_reset();
    load = 1'b1; load_data = 4'b0110;
    tick();
    load = 1'b0;
    tick();
    n_vec++;
    if ({ms_q, ms_cnt} !== {4'b0110, 32'h00010100}) begin
      n_err++; $display("FAIL eqload_setup: got q %b cnt %h, want 0110 00010100", ms_q, ms_cnt);
    end
    load = 1'b1; load_data = 4'b0110;
    for (int e = 0; e < 2; e++) begin
      tick();
      n_vec++;
      if ({ms_q, ms_chg, ms_cnt, ss_q, ss_chg, ss_cnt} !== {4'b0110, 4'b0000, 32'h00010100, 4'b0110, 4'b0000, 32'h00010100}) begin
        n_err++; $display("FAIL eqload_e%0d: got ms %b/%b/%h ss %b/%b/%h, want 0110/0000/00010100", e + 1, ms_q, ms_chg, ms_cnt, ss_q, ss_chg, ss_cnt);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    load = 1'b1; load_data = 4'b1010;
    tick();
    load = 1'b0;
    tick();
    n_vec++;
    if ({ms_q, ms_chg, ms_cnt} !== {4'b1010, 4'b1010, 32'h01000100}) begin
      n_err++; $display("FAIL midrst_pre: got q %b chg %b cnt %h, want 1010 1010 01000100", ms_q, ms_chg, ms_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ms_q, ms_qb, ms_chg, ms_cnt} !== {4'b0000, 4'b1111, 4'b0000, 32'h0}) begin
      n_err++; $display("FAIL midrst_async: got q %b qb %b chg %b cnt %h, want 0000 1111 0000 0", ms_q, ms_qb, ms_chg, ms_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_jk_truth();
    test_toggle();
    test_load_enable();
    test_saturation_clear();
    test_equal_load();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
